// File: rtl/hvgen_param_pkg.sv
// Shared timing presets, polarity constants and a width helper for the
// parametrised H/V video timing generator.
package hvgen_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    // Common arcade modes; 384 pixels x 264 lines total in each case
    localparam timing_t MODE_256X224 = '{256, 40, 32, 56, 224, 16, 8, 16};
    localparam timing_t MODE_256X192 = '{256, 40, 32, 56, 192, 32, 8, 32};
    localparam timing_t MODE_288X224 = '{288, 24, 32, 40, 224, 16, 8, 16};

    localparam bit ACTIVE_LOW  = 1'b0;
    localparam bit ACTIVE_HIGH = 1'b1;

    // Number of bits needed to represent max_val (at least 1)
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/hvgen_param_if.sv
// Pixel-side bundle of the timing generator: enable, flips, colour in/out,
// positions, blanks, syncs and strobes.
interface hvgen_param_if #(
    parameter int HW    = 9,
    parameter int VW    = 9,
    parameter int RGB_W = 12
);
    logic             i_pclk_en;
    logic             i_hflip;
    logic             i_vflip;
    logic [RGB_W-1:0] i_irgb;
    logic [RGB_W-1:0] o_orgb;
    logic [HW-1:0]    o_hpos;
    logic [VW-1:0]    o_vpos;
    logic             o_hblk;
    logic             o_vblk;
    logic             o_hsyn;
    logic             o_vsyn;
    logic             o_line_start;
    logic             o_frame_start;
    logic             o_field;

    modport master (
        input  i_pclk_en, i_hflip, i_vflip, i_irgb,
        output o_orgb, o_hpos, o_vpos, o_hblk, o_vblk, o_hsyn, o_vsyn,
               o_line_start, o_frame_start, o_field
    );

    modport slave (
        output i_pclk_en, i_hflip, i_vflip, i_irgb,
        input  o_orgb, o_hpos, o_vpos, o_hblk, o_vblk, o_hsyn, o_vsyn,
               o_line_start, o_frame_start, o_field
    );
endinterface

// File: rtl/hvgen_param_hv_axis_counter.sv
// One timing axis: modulo-TOTAL position counter with blank/sync decode of
// the current count. Used once for pixels and once for lines.
module hv_axis_counter
    import hvgen_pkg::*;
#(
    parameter int ACTIVE = 256,
    parameter int FP     = 40,
    parameter int SYNC   = 32,
    parameter int BP     = 56,
    parameter int W      = 9
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_adv,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap,
    output logic         o_blank,
    output logic         o_sync
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    // Decode bounds carry one extra bit: the sync end equals TOTAL when BP=0
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_LO  = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_HI  = (W+1)'(ACTIVE + FP + SYNC);

    if (SYNC < 1) begin : g_bad_sync
        $error("hv_axis_counter: SYNC must be at least 1");
    end
    if (W < width_for(TOTAL - 1)) begin : g_bad_width
        $error("hv_axis_counter: W too narrow for TOTAL-1");
    end

    logic [W-1:0] r_cnt;
    logic         w_last;
    logic [W:0]   w_cnt_x;

    assign w_last  = (r_cnt == LAST);
    assign w_cnt_x = {1'b0, r_cnt};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= w_last ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_wrap  = i_adv && w_last;
    assign o_blank = (w_cnt_x >= ACT_END);
    assign o_sync  = (w_cnt_x >= SYNC_LO) && (w_cnt_x < SYNC_HI);

endmodule

// File: rtl/hvgen_param.sv
// Parametrised video timing generator: registered positions, blanks, syncs,
// line/frame strobes, field toggle and blank-gated colour, all per pixel enable.
module hvgen_param
    import hvgen_pkg::*;
#(
    parameter int H_ACTIVE = MODE_256X224.h_active,
    parameter int H_FP     = MODE_256X224.h_fp,
    parameter int H_SYNC   = MODE_256X224.h_sync,
    parameter int H_BP     = MODE_256X224.h_bp,
    parameter int V_ACTIVE = MODE_256X224.v_active,
    parameter int V_FP     = MODE_256X224.v_fp,
    parameter int V_SYNC   = MODE_256X224.v_sync,
    parameter int V_BP     = MODE_256X224.v_bp,
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int RGB_W    = 12,
    parameter bit HS_POL   = ACTIVE_LOW,
    parameter bit VS_POL   = ACTIVE_LOW
) (
    input  logic           i_clk,
    input  logic           i_reset,
    hvgen_param_if.master  bus
);
    localparam logic [HW-1:0] H_LAST_ACT = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);

    logic [HW-1:0]    w_hcnt;
    logic [VW-1:0]    w_vcnt;
    logic             w_hwrap, w_vwrap;
    logic             w_hblank, w_vblank, w_hsync, w_vsync;

    logic [HW-1:0]    r_hpos;
    logic [VW-1:0]    r_vpos;
    logic             r_hblk, r_vblk, r_hsyn, r_vsyn;
    logic [RGB_W-1:0] r_rgb;
    logic             r_line_start, r_frame_start, r_field;
    logic             r_at_origin;

    hv_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
    ) u_hcnt (
        .i_clk(i_clk), .i_reset(i_reset), .i_adv(bus.i_pclk_en),
        .o_cnt(w_hcnt), .o_wrap(w_hwrap), .o_blank(w_hblank), .o_sync(w_hsync)
    );

    hv_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
    ) u_vcnt (
        .i_clk(i_clk), .i_reset(i_reset), .i_adv(w_hwrap),
        .o_cnt(w_vcnt), .o_wrap(w_vwrap), .o_blank(w_vblank), .o_sync(w_vsync)
    );

    // r_at_origin tracks (hcnt,vcnt)==(0,0): true after reset and after a frame wrap
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_hblk        <= 1'b1;
            r_vblk        <= 1'b1;
            r_hsyn        <= ~HS_POL;
            r_vsyn        <= ~VS_POL;
            r_rgb         <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_field       <= 1'b0;
            r_at_origin   <= 1'b1;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (bus.i_pclk_en) begin
                r_hblk        <= w_hblank;
                r_vblk        <= w_vblank;
                r_hsyn        <= w_hsync ? HS_POL : ~HS_POL;
                r_vsyn        <= w_vsync ? VS_POL : ~VS_POL;
                r_hpos        <= (bus.i_hflip && !w_hblank) ? H_LAST_ACT - w_hcnt : w_hcnt;
                r_vpos        <= (bus.i_vflip && !w_vblank) ? V_LAST_ACT - w_vcnt : w_vcnt;
                r_rgb         <= (r_hblk || r_vblk) ? '0 : bus.i_irgb;
                r_line_start  <= (w_hcnt == '0);
                r_frame_start <= r_at_origin;
                r_at_origin   <= w_vwrap;
                if (r_at_origin) r_field <= ~r_field;
            end
        end
    end

    assign bus.o_hpos        = r_hpos;
    assign bus.o_vpos        = r_vpos;
    assign bus.o_hblk        = r_hblk;
    assign bus.o_vblk        = r_vblk;
    assign bus.o_hsyn        = r_hsyn;
    assign bus.o_vsyn        = r_vsyn;
    assign bus.o_orgb        = r_rgb;
    assign bus.o_line_start  = r_line_start;
    assign bus.o_frame_start = r_frame_start;
    assign bus.o_field       = r_field;

endmodule

// File: tb/tb_hvgen_param.sv
// Bench for hvgen_param: a small mode (16x8 totals, active-low syncs) under
// random stimulus, plus the default mode with active-high syncs.
module tb_hvgen_param;

    logic clk;
    logic rst_a;
    logic rst_b;

    int checks = 0;
    int errors = 0;

    hvgen_param_if #(.HW(4), .VW(3), .RGB_W(12)) ifa ();
    hvgen_param_if #(.HW(9), .VW(9), .RGB_W(12)) ifb ();

    hvgen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HW(4), .VW(3), .RGB_W(12), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .i_clk(clk), .i_reset(rst_a), .bus(ifa)
    );

    hvgen_param #(
        .HW(9), .VW(9), .RGB_W(12), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .i_clk(clk), .i_reset(rst_b), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected state of the small-mode DUT
    int   n;
    bit   prev_blank;
    int   e_hpos, e_vpos;
    bit   e_hblk, e_vblk, e_hsyn, e_vsyn, e_ls, e_fs, e_field;
    logic [11:0] e_orgb;

    // Default-mode model
    int n2;
    int hs_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int h, v;
        @(posedge clk);
        #1;
        if (rst_b) begin
            chk("b_rst_hsyn", 32'(ifb.o_hsyn), 32'd0);
            chk("b_rst_vsyn", 32'(ifb.o_vsyn), 32'd0);
            chk("b_rst_hblk", 32'(ifb.o_hblk), 32'd1);
            n2 = 0;
            hs_count = 0;
        end else begin
            h = n2 % 384;
            v = (n2 / 384) % 264;
            chk("b_hsyn", 32'(ifb.o_hsyn), 32'(h >= 296 && h < 328));
            chk("b_vsyn", 32'(ifb.o_vsyn), 32'(v >= 240 && v < 248));
            chk("b_hblk", 32'(ifb.o_hblk), 32'(h >= 256));
            chk("b_hpos", 32'(ifb.o_hpos), 32'(h));
            if (v == 0 && ifb.o_hsyn === 1'b1) hs_count++;
            n2++;
            if (n2 == 384) chk("b_hsyn_width", 32'(hs_count), 32'd32);
        end
    endtask

    task automatic check_a(input string phase);
        chk({phase, "_hpos"},  32'(ifa.o_hpos), 32'(e_hpos));
        chk({phase, "_vpos"},  32'(ifa.o_vpos), 32'(e_vpos));
        chk({phase, "_hblk"},  32'(ifa.o_hblk), 32'(e_hblk));
        chk({phase, "_vblk"},  32'(ifa.o_vblk), 32'(e_vblk));
        chk({phase, "_hsyn"},  32'(ifa.o_hsyn), 32'(e_hsyn));
        chk({phase, "_vsyn"},  32'(ifa.o_vsyn), 32'(e_vsyn));
        chk({phase, "_lstart"}, 32'(ifa.o_line_start), 32'(e_ls));
        chk({phase, "_fstart"}, 32'(ifa.o_frame_start), 32'(e_fs));
        chk({phase, "_field"}, 32'(ifa.o_field), 32'(e_field));
        chk({phase, "_orgb"},  32'(ifa.o_orgb), 32'(e_orgb));
    endtask

    task automatic step(input string phase, input bit en, input bit hf, input bit vf,
                        input logic [11:0] rgb);
        int h, v;
        ifa.i_pclk_en = en;
        ifa.i_hflip   = hf;
        ifa.i_vflip   = vf;
        ifa.i_irgb    = rgb;
        tick();
        if (en) begin
            h = n % 16;
            v = (n / 16) % 8;
            e_orgb     = prev_blank ? 12'h000 : rgb;
            e_hblk     = (h >= 8);
            e_vblk     = (v >= 4);
            e_hsyn     = !(h >= 10 && h <= 12);
            e_vsyn     = !(v >= 5 && v <= 6);
            e_hpos     = (hf && h < 8) ? 7 - h : h;
            e_vpos     = (vf && v < 4) ? 3 - v : v;
            e_field    = ((n / 128) % 2) == 0;
            e_ls       = (h == 0);
            e_fs       = (h == 0 && v == 0);
            prev_blank = e_hblk | e_vblk;
            n++;
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
        check_a(phase);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        ifa.i_pclk_en = 1'b1;
        ifa.i_irgb    = 12'hFFF;
        tick();
        n = 0;
        prev_blank = 1'b1;
        e_hpos = 0; e_vpos = 0;
        e_hblk = 1'b1; e_vblk = 1'b1;
        e_hsyn = 1'b1; e_vsyn = 1'b1;
        e_ls = 1'b0; e_fs = 1'b0; e_field = 1'b0;
        e_orgb = 12'h000;
        check_a("rst");
        rst_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.i_pclk_en = 1'b0; ifa.i_hflip = 1'b0; ifa.i_vflip = 1'b0; ifa.i_irgb = '0;
        ifb.i_pclk_en = 1'b1; ifb.i_hflip = 1'b0; ifb.i_vflip = 1'b0; ifb.i_irgb = '0;
        n2 = 0;
        hs_count = 0;

        reset_a();
        rst_b = 1'b0;

        // Two full frames, continuous enable
        for (int i = 0; i < 256; i++)
            step("cont", 1'b1, 1'b0, 1'b0, 12'($urandom));

        // Enable every third clock
        for (int i = 0; i < 384; i++)
            step("en3", (i % 3) == 0, 1'b0, 1'b0, 12'($urandom));

        // Both flips, constant colour, one full frame
        for (int i = 0; i < 128; i++)
            step("flip", 1'b1, 1'b1, 1'b1, 12'hABC);

        // Random enable and flips changing mid-line
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 12'($urandom));

        // Abort mid-frame at hcnt=5, vcnt=2
        reset_a();
        for (int i = 0; i < 37; i++)
            step("pre", 1'b1, 1'b0, 1'b0, 12'($urandom));
        reset_a();
        for (int i = 0; i < 40; i++)
            step("post", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 12'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hvgen_param.md
Name: hvgen_param

Overview:
- Parametrised video timing generator; successor to the fixed 256x192 arcade hvgen.
- Produces H/V pixel positions, blanking, sync and blank-gated RGB for any resolution and porch set, at a pixel rate set by a clock enable.
- Adds the following, which the fixed generator lacks:
  - synchronous reset
  - configurable sync polarity
  - horizontal/vertical flip of reported positions
  - line-start and frame-start strobes
  - a field toggle
- Sits between the video clock domain and the per-core tile/sprite renderers and scandoubler.

Parameters:
H_ACTIVE, 256, visible pixels per line
H_FP, 40, front porch pixels (after active)
H_SYNC, 32, hsync width pixels
H_BP, 56, back porch pixels (before next active)
V_ACTIVE, 224, visible lines per frame
V_FP, 16, front porch lines
V_SYNC, 8, vsync width lines
V_BP, 16, back porch lines
HW, 9, HPOS/hcnt width; must hold H_TOTAL-1
VW, 9, VPOS/vcnt width; must hold V_TOTAL-1
RGB_W, 12, colour bus width
HS_POL, 0, hsync active level (0 = active low)
VS_POL, 0, vsync active level (0 = active low)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
PCLK_EN  in  1  pixel clock enable; all state advances only when high
HFLIP  in  1  mirror HPOS during active region
VFLIP  in  1  mirror VPOS during active region
HPOS  out  HW  registered horizontal position
VPOS  out  VW  registered vertical position
iRGB  in  RGB_W  pixel colour returned by renderer
oRGB  out  RGB_W  blank-gated colour
HBLK  out  1  horizontal blank
VBLK  out  1  vertical blank
HSYN  out  1  hsync at HS_POL
VSYN  out  1  vsync at VS_POL
LINE_START  out  1  one-CLK strobe
FRAME_START  out  1  one-CLK strobe
FIELD  out  1  toggles each frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments only when hcnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
  - Counter arithmetic is modulo at the TOTAL values; never rely on power-of-two overflow.
- RESET (takes priority over PCLK_EN, which is ignored during reset):
  - hcnt=0, vcnt=0
  - HBLK=1, VBLK=1
  - HSYN=~HS_POL, VSYN=~VS_POL
  - HPOS=0, VPOS=0, oRGB=0
  - LINE_START=0, FRAME_START=0, FIELD=0
- Reset asserted mid-frame aborts the frame immediately. No strobe is emitted on the reset cycle.
- On each PCLK_EN cycle, all decoded outputs register from the current (hcnt,vcnt), then the counters advance. Outputs therefore lag the counters by one enable, and all registered outputs stay mutually aligned.
- Decode rules:
  - HBLK = hcnt >= H_ACTIVE.
  - VBLK = vcnt >= V_ACTIVE.
  - HSYN is active when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - VSYN is active when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, so it switches on line boundaries only.
  - HPOS = HFLIP && hcnt<H_ACTIVE ? H_ACTIVE-1-hcnt : hcnt. VPOS follows the same rule with VFLIP, vcnt and V_ACTIVE. In blank regions positions are never mirrored.
  - LINE_START=1 for exactly that CLK when the registered hcnt==0; it is 0 on all other CLKs, including non-enable CLKs.
  - FRAME_START=1 likewise when hcnt==0 && vcnt==0.
  - FIELD toggles on the same enable on which FRAME_START is raised.
- RGB pipeline: oRGB <= (HBLK|VBLK) ? 0 : iRGB on PCLK_EN, using the registered blanks.
  - The renderer presents iRGB for a given HPOS by the next enable.
  - oRGB is one enable behind HPOS/HBLK. The bench aligns on this fixed latency.
- PCLK_EN held low: every output except the strobes holds; the strobes drop to 0 after one CLK.
- HFLIP and VFLIP are sampled each enable. A change mid-line takes effect on the next pixel and needs no resync.
- Zero-length porch parameters (H_FP=0, H_BP=0, etc.) are legal. H_SYNC and V_SYNC must be at least 1; the implementation asserts this at elaboration.

Decomposition:
- hvgen_pkg holds:
  - default timing constants for the team's common modes (256x224, 256x192, 288x224)
  - a clog2-style width helper
  - the polarity constants ACTIVE_LOW and ACTIVE_HIGH
- One sub-module, hv_axis_counter, instantiated twice (H, V). Parameters: ACTIVE, FP, SYNC, BP, W. Inputs: advance enable, RESET. Outputs: cnt, wrap, blank, sync.
- The top level wires the H wrap into the V advance and adds the flip, strobe, FIELD and RGB registers.

Test Plan:
- Small mode (H 8/2/3/3 -> H_TOTAL=16; V 4/1/2/1 -> V_TOTAL=8), PCLK_EN=1 continuously, 16*8*2 enables -> HBLK high 8 of every 16 enables; HSYN low on hcnt 10..12; VSYN low on lines 5..6; FRAME_START every 128 enables; FIELD 0->1->0.
- Same mode with PCLK_EN=1 every 3rd CLK -> identical output sequence per enable; LINE_START pulses are exactly 1 CLK wide.
- HFLIP=1, VFLIP=1 -> HPOS reads 7..0 then 8..15; VPOS reads 3..0 then 4..7.
- iRGB=12'hABC constant -> oRGB=12'hABC exactly one enable after HBLK falls; 0 on the enable after HBLK rises and throughout VBLK.
- RESET pulsed at hcnt=5, vcnt=2 -> next CLK all outputs at reset values; the first enable after release outputs HPOS=0, VPOS=0, LINE_START=1, FRAME_START=1.
- Defaults with HS_POL=1, VS_POL=1 -> HSYN high for 32 enables per 384-enable line; VSYN high for 8 lines per 264-line frame; reset level of both is 0.
